// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and helpers for the round-robin bus arbiter
//
// Purpose : arbiter FSM state encoding, master-count limit and the watchdog
//           counter width helper, shared by bus_arbiter and rr_priority_picker.
// Ports   : none (package).

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANTED  = 2'd1,
        ST_OWNED    = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    localparam int MAX_MASTERS = 16;

    // Width needed to count 0..timeout_cycles inclusive.
    function automatic int wd_count_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin find-first-set
//
// Purpose : finds the first set request bit at or after last_winner+1,
//           searching upward and wrapping modulo NUM_MASTERS.
// Ports   : request     in  NUM_MASTERS  request vector
//           last_winner in  IDX_W        index of the previous winner
//           valid       out 1            at least one request set
//           winner      out IDX_W        index of the selected master

module rr_priority_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [IDX_W-1:0]       last_winner,
    output logic                   valid,
    output logic [IDX_W-1:0]       winner
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(NUM_MASTERS);
    localparam logic [IDX_W:0] ONE = (IDX_W + 1)'(1);

    logic [2*NUM_MASTERS-1:0] doubled;
    logic [NUM_MASTERS-1:0]   rotated;
    logic [IDX_W:0]           start;
    logic [IDX_W:0]           pos;
    logic [IDX_W:0]           sum;

    always_comb begin
        doubled = {request, request};
        valid   = 1'b0;
        winner  = '0;
        pos     = '0;

        start = {1'b0, last_winner} + ONE;
        if (start >= N_W) begin
            start = '0;
        end

        // Concatenating the vector with itself turns the wrap-around search
        // into a plain slice: bit 0 of rotated is master 'start'.
        rotated = doubled[start +: NUM_MASTERS];

        // Scan downward so the lowest set bit is the one left in pos.
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                pos = (IDX_W + 1)'(i);
            end
        end
        valid = |rotated;

        sum = start + pos;
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        winner = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with optional stall watchdog
//
// Purpose : grants the bus to one master at a time in round-robin order,
//           follows that master's transaction (begin/end/error) and releases
//           the grant afterwards. Index 0 is the JTAG DMA.
//           Optional watchdog compiled in with macro BUS_ARBITER_WATCHDOG_EN.
// Ports   : clock               in  1            system clock
//           reset               in  1            synchronous active-high reset
//           request             in  NUM_MASTERS  per-master level request
//           granted             out NUM_MASTERS  registered one-hot grant
//           begin_transactionIN in  1            bus begin_transaction
//           end_transactionIN   in  1            bus end_transaction
//           errorIN             in  1            bus error from slave
//           end_transactionOUT  out 1            watchdog abort end_transaction
//           errorOUT            out 1            watchdog abort error
//           bus_idle            out 1            no grant active

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] request,
    output logic [NUM_MASTERS-1:0] granted,
    input  logic                   begin_transactionIN,
    input  logic                   end_transactionIN,
    input  logic                   errorIN,
    output logic                   end_transactionOUT,
    output logic                   errorOUT,
    output logic                   bus_idle
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
        $error("bus_arbiter: NUM_MASTERS out of range");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] granted_q, granted_d;
    logic [IDX_W-1:0]       last_winner_q, last_winner_d;

    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_winner;
    logic                   timeout_abort;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .request     (request),
        .last_winner (last_winner_q),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );

`ifdef BUS_ARBITER_WATCHDOG_EN
    localparam int WD_W = wd_count_width(TIMEOUT_CYCLES);
    // Arm one cycle early so the registered pulse lands on OWNED cycle
    // number TIMEOUT_CYCLES (count value TIMEOUT_CYCLES-1 in that cycle).
    localparam logic [WD_W-1:0] WD_ARM = WD_W'(TIMEOUT_CYCLES - 2);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    logic [WD_W-1:0] wd_count_q, wd_count_d;
    logic            wd_fire_q, wd_fire_d;

    always_comb begin
        wd_count_d = wd_count_q;
        wd_fire_d  = 1'b0;
        if (state_q == ST_GRANTED) begin
            wd_count_d = '0;
        end else if (state_q == ST_OWNED) begin
            wd_count_d = wd_count_q + WD_ONE;
            if (!end_transactionIN && !wd_fire_q && wd_count_q == WD_ARM) begin
                wd_fire_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_count_q <= '0;
            wd_fire_q  <= 1'b0;
        end else begin
            wd_count_q <= wd_count_d;
            wd_fire_q  <= wd_fire_d;
        end
    end

    assign timeout_abort      = wd_fire_q;
    assign end_transactionOUT = wd_fire_q;
    assign errorOUT           = wd_fire_q;
`else
    assign timeout_abort      = 1'b0;
    assign end_transactionOUT = 1'b0;
    assign errorOUT           = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        granted_d     = granted_q;
        last_winner_d = last_winner_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    granted_d              = '0;
                    granted_d[pick_winner] = 1'b1;
                    last_winner_d          = pick_winner;
                    state_d                = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (begin_transactionIN) begin
                    // begin+end together is a zero-length transaction.
                    if (end_transactionIN) begin
                        granted_d = '0;
                        state_d   = ST_RELEASE;
                    end else begin
                        state_d   = ST_OWNED;
                    end
                end else if ((request & granted_q) == '0) begin
                    // Winner withdrew before starting; just release.
                    granted_d = '0;
                    state_d   = ST_RELEASE;
                end
            end
            ST_OWNED: begin
                if (end_transactionIN || timeout_abort) begin
                    granted_d = '0;
                    state_d   = ST_RELEASE;
                end else if (errorIN) begin
                    // A slave error does not end the transaction; the master
                    // still has to drive end_transaction.
                    state_d = ST_OWNED;
                end
            end
            ST_RELEASE: begin
                granted_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                granted_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            granted_q     <= '0;
            last_winner_q <= LAST_RESET;
        end else begin
            state_q       <= state_d;
            granted_q     <= granted_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign granted  = granted_q;
    assign bus_idle = (state_q == ST_IDLE);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared system bus, on the bus side of the JTAG DMA and the other bus masters. It takes one-hot-per-master `request` lines and returns registered `granted` lines, one master at a time. It tracks the bus transaction of the granted master (begin, end, error) and releases the grant after the transaction ends. An optional watchdog force-terminates a transaction that stalls.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16); index 0 is the JTAG DMA
- TIMEOUT_CYCLES, 1023, watchdog limit in clock cycles (used only with watchdog compiled in)

Ports:
- clock  in  1  system clock; the block has one clock
- reset  in  1  synchronous, active-high reset
- request  in  NUM_MASTERS  per-master bus request, level
- granted  out  NUM_MASTERS  per-master grant, registered, at most one bit set
- begin_transactionIN  in  1  wired-OR bus begin_transaction
- end_transactionIN  in  1  wired-OR bus end_transaction
- errorIN  in  1  bus error from the addressed slave
- end_transactionOUT  out  1  arbiter-driven end_transaction, used for watchdog abort only
- errorOUT  out  1  arbiter-driven bus error, used for watchdog abort only
- bus_idle  out  1  high when no grant is active (status)

## Operation
- States: IDLE, GRANTED, OWNED, RELEASE.
- **IDLE**
  - If any `request` bit is set, pick the winner: the first set bit at or after `last_winner+1`, searching upward and wrapping modulo NUM_MASTERS.
  - Load `granted` one-hot for the winner and go to GRANTED. Update `last_winner`.
- **GRANTED**
  - `begin_transactionIN` → OWNED.
  - Winner's `request` drops before begin → RELEASE. This is a grant withdrawal, not an error.
- **OWNED**
  - `end_transactionIN` → RELEASE.
  - `errorIN` without `end_transactionIN` stays in OWNED; the master must still end the transaction.
- **RELEASE**
  - `granted` is all zero for this one cycle. Next state is IDLE.
- `end_transactionIN` and `begin_transactionIN` seen together in GRANTED: treat as a zero-length transaction and go to RELEASE.
- Requests from non-granted masters are ignored until the next IDLE. There is no pre-emption.
- `bus_idle` = (state == IDLE).
- Reset values:
  - state IDLE, `last_winner` = NUM_MASTERS-1, so master 0 wins first.
  - `granted` = 0, `end_transactionOUT` = 0, `errorOUT` = 0, `bus_idle` = 1.
- Reset asserted mid-transaction: all outputs return to reset values on the next edge. No abort pulse is issued.

## Timing
- Request to grant: `request` sampled in IDLE at edge N gives `granted` at edge N+1.
- Release to next grant: `end_transactionIN` sampled at edge N, RELEASE during cycle N+1, earliest new grant at edge N+3. Back-to-back transactions therefore have a minimum 2-cycle dead gap.
- Withdrawal: request dropped in GRANTED at edge N gives grant low at edge N+1.
- Watchdog pulses are exactly 1 cycle wide and are registered.

## Configuration
- Macro `BUS_ARBITER_WATCHDOG_EN`.
- **Defined:**
  - A 10-bit+ counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to OWNED and increments each OWNED cycle.
  - When the count reaches TIMEOUT_CYCLES without `end_transactionIN`, assert `end_transactionOUT` and `errorOUT` for one cycle, then go to RELEASE.
  - `last_winner` still advances.
- **Undefined:**
  - No counter exists. `end_transactionOUT` and `errorOUT` are tied to 0.
  - OWNED waits indefinitely.

## Structure
- Shared package `bus_arbiter_pkg`:
  - state enum (IDLE, GRANTED, OWNED, RELEASE)
  - MAX_MASTERS = 16
  - watchdog counter width function
- One sub-module `rr_priority_picker`: combinational.
  - Inputs: request vector and last winner index.
  - Outputs: valid and winner index (find-first-set over the rotated vector).

## Test plan
- After reset, `request`=4'b1111 → `granted`=4'b0001 one cycle later; then begin and end for master 0 → RELEASE, then `granted`=4'b0010.
- Fairness: all requests held high for 8 transactions → grant order 0,1,2,3,0,1,2,3 with a 2-cycle zero-grant gap between each.
- Withdrawal: `request`=4'b0100, grant given, request dropped before begin → `granted`=0 next cycle; `last_winner`=2, so the next request 4'b0101 grants master 0.
- Reset mid-OWNED (master 3 granted) → `granted`=0, `bus_idle`=1 at the next edge; the following request 4'b1000 grants master 3.
- With `BUS_ARBITER_WATCHDOG_EN` and TIMEOUT_CYCLES=16: begin with no end → `end_transactionOUT`=`errorOUT`=1 exactly at OWNED cycle 16, then the grant drops. Without the macro: no pulse after 100 cycles and the grant is still held.
- Simultaneous begin+end in GRANTED → RELEASE the next cycle, with no watchdog activity.
